ptw_dmem_bridge: RTL and testbench
==================================

# ptw_dmem_bridge

Memory-side responder for the page-table walker's dmem port. It accepts PTW requests (PTE read `M_XRD`, atomic OR `M_XA_OR` used to set the A/D bits) and serves them over a simple req/gnt/rvalid memory port. It returns either a data response or a nack so that the walker retries. It sits between the `ptw` dmem interface and the L2/memory fabric, replacing the shared dcache path for page-table traffic.

## Interface
- `ADDR_WIDTH`, default `SIZE_VADDR+1`: width of `req.addr` and `mem_addr_o`.
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles to wait for `mem_rvalid_i` before nacking.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `ptw_dmem_comm_i` in `ptw_dmem_comm_t`: request from the PTW (valid, phys, cmd, typ, addr, kill, data).
- `dmem_ptw_comm_o` out `dmem_ptw_comm_t`: response to the PTW (dmem_ready, resp.valid, resp.nack, resp.data).
- `mem_req_o` out 1: memory request valid.
- `mem_gnt_i` in 1: memory grant.
- `mem_we_o` out 1: 1 for a write, 0 for a read.
- `mem_addr_o` out `ADDR_WIDTH`: doubleword-aligned address.
- `mem_wdata_o` out 64: write data.
- `mem_be_o` out 8: byte enables, always `8'hFF`.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in 64: read data.
- `mem_err_i` in 1: bus error, qualified by `mem_rvalid_i`.

## Operation
- FSM states:
  - IDLE
  - RD_REQ
  - RD_WAIT
  - WR_REQ
  - RESP
  - NACK
- IDLE: `dmem_ready`=1.
  - On `req.valid`, the address, cmd, typ, kill and data are latched.
  - If kill=1, the request is dropped and the FSM stays in IDLE.
  - If cmd is not `M_XRD` or `M_XA_OR`, or typ≠`MT_D`, or addr[2:0]≠0, go to NACK.
  - Otherwise go to RD_REQ.
- RD_REQ: `mem_req_o`=1, `mem_we_o`=0. Go to RD_WAIT on `mem_gnt_i`.
- RD_WAIT:
  - The timeout counter increments each cycle.
  - On `mem_rvalid_i` with `mem_err_i`=1, go to NACK (see Configuration).
  - On `mem_rvalid_i` with `mem_err_i`=0, register old data.
    - cmd=`M_XRD`: go to RESP.
    - cmd=`M_XA_OR`: go to WR_REQ.
  - Counter reaching `TIMEOUT_CYCLES` with no rvalid: go to NACK.
- WR_REQ: `mem_req_o`=1, `mem_we_o`=1, `mem_wdata_o` = old | latched data. Go to RESP on `mem_gnt_i`; a write completes at grant.
- RESP: `resp.valid`=1 for one cycle with `resp.data` = registered read data. For an AMO this is the pre-OR value. Then go to IDLE.
- NACK: `resp.nack`=1 for one cycle, `resp.data`=0, then go to IDLE.
- `resp.valid` and `resp.nack` are never both high.
- Only one transaction is outstanding at a time.
- A `mem_rvalid_i` seen outside RD_WAIT is ignored. This covers stale returns after a reset or timeout.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_ready`=1.
  - `resp.valid`=0, `resp.nack`=0, `resp.data`=0.
  - `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
  - Timeout counter 0.
  - `mem_be_o` = `8'hFF` at all times.
- Read latency: accept at cycle 0, `mem_req_o` at cycle 1. With grant at cycle 1 and rvalid at cycle 1+L, `resp.valid` is at cycle 2+L.
- AMO adds one write-grant cycle: `resp.valid` is at cycle 3+L when the write is granted immediately.
- Illegal request: `resp.nack` at cycle 1.
- Reset mid-transaction aborts with no response. A request held in `mem_req_o` is withdrawn; the fabric must tolerate a request withdrawn by reset.
- `mem_req_o` stays asserted, with address/data stable, until granted.
- The timeout counter clears on entry to RD_WAIT.

## Configuration
- `PTW_DMEM_ERR_NACK_EN` defined: `mem_err_i` causes NACK, so the PTW retries.
- `PTW_DMEM_ERR_NACK_EN` undefined: `mem_err_i` causes RESP with `resp.data`=0. The walker sees V=0 and raises a page fault.
- For an AMO with an error, neither setting issues the write.
- Timeout always nacks, regardless of the macro.

## Structure
- `mmu_pkg` holds:
  - The `M_XRD`, `M_XA_OR` and `MT_D` constants, moved there from the walker so both ends share them.
  - The bridge state enum `ptw_bridge_state_t`.
- The walker must import these constants from `mmu_pkg` rather than redefine them locally.
- No sub-module is needed; the timeout counter is inline.

## Test plan
- Read: `M_XRD` addr `0x8000_1008`, grant immediately, rvalid after 3 cycles with data `0x2000_0C01` → `resp.valid` at cycle 5, data `0x2000_0C01`, no write issued.
- AMO: `M_XA_OR` data `0x40`, memory old `0x2000_0C0F` → write `0x2000_0C4F` to the same address, `resp.data` = `0x2000_0C0F`.
- Illegal request: addr `0x...1004` or cmd `5'b00001` → `resp.nack` at cycle 1, no `mem_req_o`.
- Timeout: with `TIMEOUT_CYCLES`=4 and no rvalid → nack after 4 wait cycles; a late rvalid is then ignored and `dmem_ready` is back at 1.
- Bus error: rvalid with `mem_err_i` → nack with the macro defined; `resp.valid` with data 0 without it.
- Reset asserted in RD_WAIT → all outputs at reset values immediately; a later rvalid produces no response.

Source files
------------

// File: rtl/mmu_pkg.sv
// mmu_pkg: constants and types shared by the page-table walker and its
// dmem-side bridge (ptw_dmem_bridge).
//
// Contents:
//   SIZE_VADDR, PTW_ADDR_W   virtual-address sizing for the PTW dmem port
//   M_XRD, M_XA_OR, MT_D     memory command / type encodings used by the walker
//   ptw_dmem_comm_t          PTW -> dmem request bundle
//   dmem_ptw_comm_t          dmem -> PTW response bundle
//   ptw_bridge_state_t       bridge FSM state encoding
//   ptw_req_legal()          request legality check used on acceptance
package mmu_pkg;

    localparam int SIZE_VADDR = 39;
    localparam int PTW_ADDR_W = SIZE_VADDR + 1;

    localparam logic [4:0] M_XRD   = 5'b00000;
    localparam logic [4:0] M_XA_OR = 5'b01010;
    localparam logic [2:0] MT_D    = 3'b011;

    typedef struct packed {
        logic                  valid;
        logic                  phys;
        logic [4:0]            cmd;
        logic [2:0]            typ;
        logic [PTW_ADDR_W-1:0] addr;
        logic                  kill;
        logic [63:0]           data;
    } ptw_dmem_comm_t;

    typedef struct packed {
        logic        valid;
        logic        nack;
        logic [63:0] data;
    } dmem_resp_t;

    typedef struct packed {
        logic       dmem_ready;
        dmem_resp_t resp;
    } dmem_ptw_comm_t;

    typedef enum logic [2:0] {
        PB_IDLE,
        PB_RD_REQ,
        PB_RD_WAIT,
        PB_WR_REQ,
        PB_RESP,
        PB_NACK
    } ptw_bridge_state_t;

    // Only doubleword PTE reads and the A/D-bit atomic OR are served.
    function automatic logic ptw_req_legal(input logic [4:0] cmd,
                                           input logic [2:0] typ,
                                           input logic [2:0] addr_lo);
        return ((cmd == M_XRD) || (cmd == M_XA_OR)) &&
               (typ == MT_D) && (addr_lo == 3'b000);
    endfunction

endpackage

// File: rtl/ptw_dmem_bridge.sv
// ptw_dmem_bridge: memory-side responder for the page-table walker dmem port.
// Serves PTE reads (M_XRD) and A/D-bit atomic ORs (M_XA_OR) over a simple
// req/gnt/rvalid memory port and answers the walker with a data response or
// a nack (walker retries). One transaction outstanding at a time.
//
// Parameters:
//   ADDR_WIDTH      width of the request address and mem_addr_o
//   TIMEOUT_CYCLES  RD_WAIT cycles allowed before the read is nacked
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   ptw_dmem_comm_i    request from the walker
//   dmem_ptw_comm_o    ready / response to the walker
//   mem_req_o/gnt_i    memory request handshake (held until granted)
//   mem_we_o           1 = write (AMO write-back), 0 = read
//   mem_addr_o         doubleword-aligned address
//   mem_wdata_o        write data (old | OR operand)
//   mem_be_o           byte enables, constant 8'hFF
//   mem_rvalid_i       read data valid (ignored outside RD_WAIT)
//   mem_rdata_i        read data
//   mem_err_i          bus error, qualified by mem_rvalid_i
//
// Build option:
//   PTW_DMEM_ERR_NACK_EN  defined: bus error -> nack (walker retries)
//                         undefined: bus error -> response with data 0
//                         (walker sees V=0 and raises a page fault)
//
// state      | meaning
// -----------+----------------------------------------------------------
// PB_IDLE    | ready for a request; latch and classify on valid
// PB_RD_REQ  | read request on the memory port, waiting for grant
// PB_RD_WAIT | read granted, waiting for rvalid or timeout
// PB_WR_REQ  | AMO write-back request, waiting for grant
// PB_RESP    | one-cycle data response to the walker
// PB_NACK    | one-cycle nack to the walker
module ptw_dmem_bridge
    import mmu_pkg::*;
#(
    parameter int ADDR_WIDTH     = SIZE_VADDR + 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  ptw_dmem_comm_t        ptw_dmem_comm_i,
    output dmem_ptw_comm_t        dmem_ptw_comm_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [63:0]           mem_wdata_o,
    output logic [7:0]            mem_be_o,
    input  logic                  mem_rvalid_i,
    input  logic [63:0]           mem_rdata_i,
    input  logic                  mem_err_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ptw_bridge_state_t     state_q;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic                  resp_nack_q;
    logic [63:0]           resp_data_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-4:0] addr_q;
    logic [63:0]           wdata_q;
    logic [63:0]           or_data_q;
    logic                  amo_q;
    logic [CNT_W-1:0]      cnt_q;

    logic unused_phys;
    assign unused_phys = ptw_dmem_comm_i.phys;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= PB_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_nack_q  <= 1'b0;
            resp_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            or_data_q    <= '0;
            amo_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // Response strobes are single-cycle pulses.
            resp_valid_q <= 1'b0;
            resp_nack_q  <= 1'b0;
            case (state_q)
                PB_IDLE: begin
                    if (ptw_dmem_comm_i.valid && !ptw_dmem_comm_i.kill) begin
                        addr_q    <= ptw_dmem_comm_i.addr[ADDR_WIDTH-1:3];
                        or_data_q <= ptw_dmem_comm_i.data;
                        amo_q     <= (ptw_dmem_comm_i.cmd == M_XA_OR);
                        ready_q   <= 1'b0;
                        if (ptw_req_legal(ptw_dmem_comm_i.cmd, ptw_dmem_comm_i.typ,
                                          ptw_dmem_comm_i.addr[2:0])) begin
                            state_q   <= PB_RD_REQ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                        end else begin
                            state_q     <= PB_NACK;
                            resp_nack_q <= 1'b1;
                            resp_data_q <= '0;
                        end
                    end
                end
                PB_RD_REQ: begin
                    if (mem_gnt_i) begin
                        state_q   <= PB_RD_WAIT;
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                PB_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (mem_err_i) begin
                            // An erroring AMO never issues its write-back.
`ifdef PTW_DMEM_ERR_NACK_EN
                            state_q     <= PB_NACK;
                            resp_nack_q <= 1'b1;
                            resp_data_q <= '0;
`else
                            state_q      <= PB_RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
`endif
                        end else begin
                            // Old value is what the walker sees, even for an AMO.
                            resp_data_q <= mem_rdata_i;
                            if (amo_q) begin
                                state_q   <= PB_WR_REQ;
                                mem_req_q <= 1'b1;
                                mem_we_q  <= 1'b1;
                                wdata_q   <= mem_rdata_i | or_data_q;
                            end else begin
                                state_q      <= PB_RESP;
                                resp_valid_q <= 1'b1;
                            end
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= PB_NACK;
                        resp_nack_q <= 1'b1;
                        resp_data_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PB_WR_REQ: begin
                    // Write is complete at grant; no write response expected.
                    if (mem_gnt_i) begin
                        state_q      <= PB_RESP;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                    end
                end
                PB_RESP: begin
                    state_q     <= PB_IDLE;
                    ready_q     <= 1'b1;
                    resp_data_q <= '0;
                end
                PB_NACK: begin
                    state_q <= PB_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= PB_IDLE;
                    ready_q   <= 1'b1;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_ptw_comm_o.dmem_ready = ready_q;
    assign dmem_ptw_comm_o.resp.valid = resp_valid_q;
    assign dmem_ptw_comm_o.resp.nack  = resp_nack_q;
    assign dmem_ptw_comm_o.resp.data  = resp_data_q;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = {addr_q, 3'b000};
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = 8'hFF;

endmodule

// File: tb/tb_ptw_dmem_bridge.sv
// Directed testbench for ptw_dmem_bridge. "cycle n" below means the interval
// just after the n-th rising edge following request presentation; inputs are
// driven and outputs sampled 1 time unit after a rising edge.
module tb_ptw_dmem_bridge;
    import mmu_pkg::*;

    localparam int AW = SIZE_VADDR + 1;

    logic           clk = 1'b0;
    logic           rst;
    ptw_dmem_comm_t req;
    dmem_ptw_comm_t rsp;
    logic           mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
    logic [AW-1:0]  mem_addr;
    logic [63:0]    mem_wdata, mem_rdata;
    logic [7:0]     mem_be;

    int tests  = 0;
    int failed = 0;

    ptw_dmem_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ptw_dmem_comm_i (req),
        .dmem_ptw_comm_o (rsp),
        .mem_req_o       (mem_req),
        .mem_gnt_i       (mem_gnt),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_be_o        (mem_be),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rdata_i     (mem_rdata),
        .mem_err_i       (mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] cmd, input logic [AW-1:0] addr,
                        input logic [63:0] data, input logic kill);
        req.valid = 1'b1;
        req.phys  = 1'b1;
        req.cmd   = cmd;
        req.typ   = MT_D;
        req.addr  = addr;
        req.data  = data;
        req.kill  = kill;
    endtask

    initial begin
        req        = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_err    = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        chk("rst_ready",  64'(rsp.dmem_ready), 64'd1);
        chk("rst_valid",  64'(rsp.resp.valid), 64'd0);
        chk("rst_nack",   64'(rsp.resp.nack),  64'd0);
        chk("rst_data",   rsp.resp.data,       64'd0);
        chk("rst_req",    64'(mem_req),        64'd0);
        chk("rst_we",     64'(mem_we),         64'd0);
        chk("rst_addr",   64'(mem_addr),       64'd0);
        chk("rst_wdata",  mem_wdata,           64'd0);
        chk("rst_be",     64'(mem_be),         64'hFF);
        rst = 1'b0;
        tick();

        // Read: grant immediately, rvalid at cycle 4 (L=3) -> resp at cycle 5.
        mem_gnt = 1'b1;
        send(M_XRD, 40'h80001008, 64'd0, 1'b0);
        tick();                                         // cycle 1
        req.valid = 1'b0;
        chk("rd_req_c1",   64'(mem_req),  64'd1);
        chk("rd_we_c1",    64'(mem_we),   64'd0);
        chk("rd_addr_c1",  64'(mem_addr), 64'h80001008);
        chk("rd_ready_c1", 64'(rsp.dmem_ready), 64'd0);
        tick();                                         // cycle 2
        chk("rd_req_c2",   64'(mem_req),  64'd0);
        tick();                                         // cycle 3
        tick();                                         // cycle 4
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h20000C01;
        chk("rd_novalid_c4", 64'(rsp.resp.valid), 64'd0);
        tick();                                         // cycle 5
        mem_rvalid = 1'b0;
        chk("rd_valid_c5", 64'(rsp.resp.valid), 64'd1);
        chk("rd_nack_c5",  64'(rsp.resp.nack),  64'd0);
        chk("rd_data_c5",  rsp.resp.data,       64'h20000C01);
        chk("rd_nowrite",  64'(mem_req),        64'd0);
        tick();                                         // cycle 6
        chk("rd_valid_c6", 64'(rsp.resp.valid), 64'd0);
        chk("rd_ready_c6", 64'(rsp.dmem_ready), 64'd1);

        // AMO: old 0x2000_0C0F | 0x40, rvalid at cycle 2, write grant delayed one cycle.
        send(M_XA_OR, 40'h80002010, 64'h40, 1'b0);
        tick();                                         // cycle 1
        req.valid = 1'b0;
        chk("amo_rdreq_c1", 64'(mem_req), 64'd1);
        chk("amo_rdwe_c1",  64'(mem_we),  64'd0);
        tick();                                         // cycle 2
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h20000C0F;
        mem_gnt    = 1'b0;
        tick();                                         // cycle 3
        mem_rvalid = 1'b0;
        chk("amo_wrreq_c3", 64'(mem_req),  64'd1);
        chk("amo_we_c3",    64'(mem_we),   64'd1);
        chk("amo_wdata_c3", mem_wdata,     64'h20000C4F);
        chk("amo_addr_c3",  64'(mem_addr), 64'h80002010);
        chk("amo_novalid_c3", 64'(rsp.resp.valid), 64'd0);
        tick();                                         // cycle 4: still ungranted
        mem_gnt = 1'b1;
        chk("amo_hold_req", 64'(mem_req),  64'd1);
        chk("amo_hold_wd",  mem_wdata,     64'h20000C4F);
        tick();                                         // cycle 5
        chk("amo_valid",   64'(rsp.resp.valid), 64'd1);
        chk("amo_data",    rsp.resp.data,       64'h20000C0F);
        chk("amo_req_off", 64'(mem_req),        64'd0);
        tick();

        // Illegal: misaligned address.
        send(M_XRD, 40'h80001004, 64'd0, 1'b0);
        tick();
        req.valid = 1'b0;
        chk("ill_addr_nack",  64'(rsp.resp.nack),  64'd1);
        chk("ill_addr_valid", 64'(rsp.resp.valid), 64'd0);
        chk("ill_addr_req",   64'(mem_req),        64'd0);
        chk("ill_addr_data",  rsp.resp.data,       64'd0);
        tick();
        chk("ill_addr_nack2", 64'(rsp.resp.nack),  64'd0);
        chk("ill_addr_ready", 64'(rsp.dmem_ready), 64'd1);

        // Illegal: unsupported command.
        send(5'b00001, 40'h80001008, 64'd0, 1'b0);
        tick();
        req.valid = 1'b0;
        chk("ill_cmd_nack", 64'(rsp.resp.nack), 64'd1);
        chk("ill_cmd_req",  64'(mem_req),       64'd0);
        tick();

        // Killed request is dropped.
        send(M_XRD, 40'h80001008, 64'd0, 1'b1);
        tick();
        req = '0;
        chk("kill_ready", 64'(rsp.dmem_ready), 64'd1);
        chk("kill_req",   64'(mem_req),        64'd0);
        chk("kill_nack",  64'(rsp.resp.nack),  64'd0);

        // Timeout: RD_WAIT cycles 2..5, nack at cycle 6, late rvalid ignored.
        send(M_XRD, 40'h80003000, 64'd0, 1'b0);
        tick();                                         // cycle 1
        req.valid = 1'b0;
        tick();                                         // cycle 2
        tick();                                         // cycle 3
        tick();                                         // cycle 4
        tick();                                         // cycle 5
        chk("to_nonack_c5", 64'(rsp.resp.nack), 64'd0);
        tick();                                         // cycle 6
        chk("to_nack_c6",   64'(rsp.resp.nack),  64'd1);
        chk("to_valid_c6",  64'(rsp.resp.valid), 64'd0);
        tick();                                         // cycle 7
        chk("to_ready_c7",  64'(rsp.dmem_ready), 64'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hABCD;
        tick();                                         // cycle 8
        mem_rvalid = 1'b0;
        chk("to_late_valid", 64'(rsp.resp.valid), 64'd0);
        chk("to_late_nack",  64'(rsp.resp.nack),  64'd0);
        chk("to_late_ready", 64'(rsp.dmem_ready), 64'd1);

        // Bus error on an AMO read: never writes back.
        send(M_XA_OR, 40'h80004000, 64'h40, 1'b0);
        tick();                                         // cycle 1
        req.valid = 1'b0;
        tick();                                         // cycle 2
        mem_rvalid = 1'b1;
        mem_err    = 1'b1;
        mem_rdata  = 64'hDEAD;
        tick();                                         // cycle 3
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        chk("err_nowrite", 64'(mem_req), 64'd0);
`ifdef PTW_DMEM_ERR_NACK_EN
        chk("err_nack",  64'(rsp.resp.nack),  64'd1);
        chk("err_valid", 64'(rsp.resp.valid), 64'd0);
`else
        chk("err_nack",  64'(rsp.resp.nack),  64'd0);
        chk("err_valid", 64'(rsp.resp.valid), 64'd1);
`endif
        chk("err_data", rsp.resp.data, 64'd0);
        tick();

        // Reset while in RD_WAIT; a later rvalid produces nothing.
        send(M_XRD, 40'h80005008, 64'd0, 1'b0);
        tick();                                         // cycle 1
        req.valid = 1'b0;
        tick();                                         // cycle 2: RD_WAIT
        chk("rw_ready_pre", 64'(rsp.dmem_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rw_ready", 64'(rsp.dmem_ready), 64'd1);
        chk("rw_addr",  64'(mem_addr),       64'd0);
        chk("rw_req",   64'(mem_req),        64'd0);
        chk("rw_valid", 64'(rsp.resp.valid), 64'd0);
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1234;
        tick();
        mem_rvalid = 1'b0;
        chk("rw_stale_valid", 64'(rsp.resp.valid), 64'd0);
        chk("rw_stale_ready", 64'(rsp.dmem_ready), 64'd1);
        tick();
        chk("rw_stale_valid2", 64'(rsp.resp.valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
